temp_sampler: RTL and testbench
===============================

# temp_sampler

Front-end stage feeding the incubator controller's signed 8-bit `sensor` input. Periodically reads one 8-bit two's-complement temperature frame from a serial digital sensor (chip-select/clock/data, MSB first), rejects fault frames, filters valid samples with a 4-tap moving average, and presents a registered, stable temperature with a one-cycle update strobe. The controller samples `sensor` on its own clock, so the output must never glitch between updates.

## Interface
- `SAMPLE_DIV`, default 1000: clk cycles between frame starts; legal range 20..65535.
- `RESET_TEMP`, default 25: signed value driven on `sensor` from reset until the first accepted sample. 25 lies inside the controller's idle band, so neither heater nor cooler is demanded.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `sdo`, input, 1: serial data from the sensor.
- `cs_n`, output, 1: sensor chip select, active low.
- `sclk`, output, 1: serial clock to the sensor, clk/2 during a frame.
- `sensor`, output, 8, signed: filtered temperature in °C.
- `sample_valid`, output, 1: one-cycle pulse in the cycle `sensor` takes a new value.
- `fault`, output, 1: sticky flag; set by a fault frame, cleared by the next accepted frame.

## Operation
- Reset values: `cs_n`=1, `sclk`=0, `sensor`=RESET_TEMP, `sample_valid`=0, `fault`=0, divider=0, FSM=IDLE, average window marked empty.
- Divider is 16 bits and free-running. It counts 0..SAMPLE_DIV-1, then wraps to 0. The wrap cycle is the frame tick.
- FSM states:
  - IDLE: on a tick, go to SELECT.
  - SELECT: drive `cs_n`=0 and `sclk`=0 for one cycle, then go to SHIFT.
  - SHIFT: 8 bits, 2 cycles each. Phase 0 drives `sclk`=0. Phase 1 drives `sclk`=1, and `sdo` is shifted into the LSB of the shift register at the end of phase 1. After bit 7 go to DONE.
  - DONE: drive `cs_n`=1 and `sclk`=0, evaluate the frame, then go to UPDATE.
  - UPDATE: write the result and return to IDLE.
- A tick arriving while the FSM is not in IDLE is dropped; it is never queued. With SAMPLE_DIV≥20, ticks only occur in IDLE.
- A frame value of 8'h80 (-128) is a fault frame:
  - `fault` is set.
  - `sensor`, the averaging window and `sample_valid` are left unchanged.
- Any other frame is accepted:
  - `fault` is cleared.
  - The sample is pushed into the 4-entry window, replacing the oldest entry.
  - If the window is empty, all 4 entries are loaded with the sample.
- Average:
  - 10-bit signed sum of the 4 entries, arithmetically shifted right by 2, which floors toward -∞.
  - The result always fits in 8 bits signed; no saturation is needed.
- Asserting reset mid-frame aborts immediately: `cs_n`=1, the partial frame is discarded and the window is emptied.

## Timing
- Let cycle T be the tick cycle.
  - T+1: `cs_n` falls (SELECT).
  - T+2..T+17: SHIFT.
  - T+18: DONE, `cs_n` rises.
  - T+19: UPDATE.
  - T+20: registered `sensor` and `sample_valid` become visible.
- `sclk` rises at T+3, T+5, …, T+17, giving 8 rising edges per frame. `sdo` must be stable during each `sclk`-high cycle.
- First tick after reset release occurs at cycle SAMPLE_DIV-1, counted from the first clock edge after release.
- Frame period: exactly SAMPLE_DIV cycles.
- `sensor` changes only with `sample_valid`=1 and is constant between pulses.

## Configuration
- `TEMP_SAMPLER_AVG_EN` defined: 4-tap moving average as described above.
- `TEMP_SAMPLER_AVG_EN` undefined:
  - The window and adder are not built.
  - An accepted frame is written to `sensor` unfiltered, with identical timing and identical `sample_valid` and `fault` behaviour.

## Test plan
- Reset, then hold `rst`=0 for 5 cycles → `sensor`=25, `cs_n`=1, `sclk`=0, `fault`=0; release and check the first `cs_n` fall at cycle SAMPLE_DIV.
- SAMPLE_DIV=20, sensor model returns 8'd40 → 8 `sclk` rising edges while `cs_n`=0; `sensor`=40 with a one-cycle `sample_valid` at T+20 (window preloaded).
- Frame sequence 40, 0, 0, 0 with AVG_EN → `sensor` outputs are 40, 30, 20, 10; without AVG_EN → 40, 0, 0, 0.
- Frame sequence -3, -4 with AVG_EN → -3, then (-3·3-4)>>>2 = -4 (floor check).
- Frame 8'h80 after `sensor`=40 → `fault`=1, no `sample_valid`, `sensor` stays 40; next frame 36 → `fault`=0, `sensor`=39 with AVG_EN.
- Assert `rst` at T+9 (mid-SHIFT) → `cs_n`=1 asynchronously, `sensor`=25; next accepted frame 50 → `sensor`=50 (window refilled).

Source files
------------

// File: rtl/temp_sampler.sv
// Purpose : periodic serial temperature read, fault-frame rejection, optional 4-tap moving average.
// Latency : sensor/sample_valid update 20 cycles after the frame tick (tick at T, visible at T+20).
// Backpress: none; a tick arriving while a frame is in flight is dropped, never queued.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - asynchronous, active-low reset
//   sdo          - serial data from the sensor, MSB first
//   cs_n         - sensor chip select, active low (registered)
//   sclk         - serial clock, clk/2 during a frame (registered)
//   sensor       - signed 8-bit filtered temperature (registered, changes only with sample_valid)
//   sample_valid - one-cycle pulse in the cycle sensor takes a new value
//   fault        - sticky fault flag, set by an 8'h80 frame, cleared by the next accepted frame
// Build option: define TEMP_SAMPLER_AVG_EN to build the 4-tap moving average;
//   otherwise accepted frames are passed to sensor unfiltered with identical timing.
module temp_sampler #(
    parameter int unsigned       SAMPLE_DIV = 1000,
    parameter logic signed [7:0] RESET_TEMP = 8'sd25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdo,
    output logic              cs_n,
    output logic              sclk,
    output logic signed [7:0] sensor,
    output logic              sample_valid,
    output logic              fault
);

    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, DONE, UPDATE} state_t;

    state_t            state;
    logic [15:0]       div_cnt;
    logic              tick;
    logic [2:0]        bit_cnt;
    logic              phase;
    logic [7:0]        shreg;
    logic              frame_ok;
    logic              accepted;
    logic signed [7:0] result;

    // Free-running divider; the wrap cycle is the frame tick.
    assign tick     = (div_cnt == 16'(SAMPLE_DIV - 1));
    assign frame_ok = (shreg != 8'h80);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

`ifdef TEMP_SAMPLER_AVG_EN
    logic signed [7:0] win [4];
    logic [1:0]        wr_ptr;
    logic              win_full;
    logic signed [9:0] sum;

    // Window is written in DONE so the sum is settled when UPDATE registers it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) win[i] <= '0;
            wr_ptr   <= '0;
            win_full <= 1'b0;
        end else if (state == DONE && frame_ok) begin
            if (!win_full) begin
                // First sample after reset preloads every tap so the output starts at the sample.
                for (int i = 0; i < 4; i++) win[i] <= shreg;
                wr_ptr   <= 2'd0;
                win_full <= 1'b1;
            end else begin
                win[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 2'd1;
            end
        end
    end

    always_comb begin
        sum = 10'(win[0]) + 10'(win[1]) + 10'(win[2]) + 10'(win[3]);
    end

    // Arithmetic shift floors toward -inf; the quotient of four 8-bit values always fits 8 bits.
    assign result = 8'(sum >>> 2);
`else
    logic signed [7:0] last_sample;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_sample <= '0;
        end else if (state == DONE && frame_ok) begin
            last_sample <= shreg;
        end
    end

    assign result = last_sample;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cs_n         <= 1'b1;
            sclk         <= 1'b0;
            bit_cnt      <= '0;
            phase        <= 1'b0;
            shreg        <= '0;
            accepted     <= 1'b0;
            sensor       <= RESET_TEMP;
            sample_valid <= 1'b0;
            fault        <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SELECT;
                        cs_n  <= 1'b0;
                        sclk  <= 1'b0;
                    end
                end
                SELECT: begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                    phase   <= 1'b0;
                end
                SHIFT: begin
                    if (!phase) begin
                        phase <= 1'b1;
                        sclk  <= 1'b1;
                    end else begin
                        // Sample at the end of the sclk-high cycle, when sdo is stable.
                        shreg <= {shreg[6:0], sdo};
                        phase <= 1'b0;
                        sclk  <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            state <= DONE;
                            cs_n  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                DONE: begin
                    accepted <= frame_ok;
                    fault    <= ~frame_ok;
                    state    <= UPDATE;
                end
                UPDATE: begin
                    if (accepted) begin
                        sensor       <= result;
                        sample_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_sampler.sv
// Purpose : directed bench for temp_sampler with a behavioural serial sensor.
// Latency : frames expected every 20 cycles (SAMPLE_DIV=20), result visible 19 cycles after cs_n falls.
// Backpress: n/a.
module tb_temp_sampler;

`ifdef TEMP_SAMPLER_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sdo = 1'b0;
    logic              cs_n;
    logic              sclk;
    logic signed [7:0] sensor;
    logic              sample_valid;
    logic              fault;

    int         checks     = 0;
    int         errors     = 0;
    logic [7:0] model_frame = 8'h00;
    int         nb         = 0;
    int         sclk_edges = 0;

    temp_sampler #(.SAMPLE_DIV(20), .RESET_TEMP(8'sd25)) dut (
        .clk          (clk),
        .rst          (rst),
        .sdo          (sdo),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .sensor       (sensor),
        .sample_valid (sample_valid),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Sensor model: presents the next MSB-first bit while sclk is low, holds it through sclk high.
    always @(negedge clk) begin
        if (cs_n !== 1'b0) nb = 0;
        else if (sclk === 1'b1) nb++;
        else if (nb < 8) sdo = model_frame[7 - nb];
    end

    always @(posedge sclk) begin
        if (cs_n === 1'b0) sclk_edges++;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs one frame: waits for cs_n low (cycle T+1), watches T+2..T+20, returns at T+21.
    task automatic run_frame(input logic [7:0] f, output int nvld, output int lat, output logic vld_after);
        int n = 0;
        model_frame = f;
        nvld = 0;
        lat  = -1;
        while (cs_n !== 1'b0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("frame_start", cs_n, 0);
        sclk_edges = 0;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk); #1;
            if (sample_valid === 1'b1) begin
                nvld++;
                if (lat < 0) lat = k;
            end
        end
        @(posedge clk); #1;
        vld_after = sample_valid;
    endtask

    initial begin
        int   n;
        int   nvld;
        int   lat;
        logic va;

        // Reset state
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_sensor", sensor, 25);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_fault", fault, 0);
        chk("rst_valid", sample_valid, 0);

        // First cs_n fall SAMPLE_DIV edges after release
        model_frame = 8'd40;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (cs_n !== 1'b0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("first_cs_fall", n, 20);

        // Frame sequence 40, 0, 0, 0
        run_frame(8'd40, nvld, lat, va);
        chk("f40_sclk_edges", sclk_edges, 8);
        chk("f40_latency", lat, 19);
        chk("f40_npulse", nvld, 1);
        chk("f40_pulse_end", va, 0);
        chk("f40_sensor", sensor, 40);
        chk("f40_fault", fault, 0);
        run_frame(8'd0, nvld, lat, va);
        chk("seq2_sensor", sensor, AVG ? 30 : 0);
        chk("seq2_latency", lat, 19);
        run_frame(8'd0, nvld, lat, va);
        chk("seq3_sensor", sensor, AVG ? 20 : 0);
        run_frame(8'd0, nvld, lat, va);
        chk("seq4_sensor", sensor, AVG ? 10 : 0);

        // Fault frame after 40, then recovery with 36
        do_reset();
        run_frame(8'd40, nvld, lat, va);
        chk("pre_fault_sensor", sensor, 40);
        run_frame(8'h80, nvld, lat, va);
        chk("fault_set", fault, 1);
        chk("fault_no_pulse", nvld, 0);
        chk("fault_sensor_hold", sensor, 40);
        run_frame(8'd36, nvld, lat, va);
        chk("recover_fault_clr", fault, 0);
        chk("recover_latency", lat, 19);
        chk("recover_sensor", sensor, AVG ? 39 : 36);

        // Negative values and floor behaviour
        do_reset();
        run_frame(8'hFD, nvld, lat, va);
        chk("neg3_sensor", sensor, -3);
        run_frame(8'hFC, nvld, lat, va);
        chk("floor_sensor", sensor, -4);

        // Mid-shift reset aborts the frame and empties the window
        do_reset();
        run_frame(8'd40, nvld, lat, va);
        chk("pre_abort_sensor", sensor, 40);
        model_frame = 8'h11;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_in_frame", cs_n, 0);
        rst = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_sensor", sensor, 25);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_frame(8'd50, nvld, lat, va);
        chk("refill_latency", lat, 19);
        chk("refill_sensor", sensor, 50);
        chk("refill_fault", fault, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
